fakeram45_1r1w_gen: RTL and testbench
=====================================

// Module: fakeram45_1r1w_gen
// PURPOSE
//  Parametrised behavioural SRAM macro model: one read port, one write port, per-bit write mask.
//  Adds a configurable read pipeline depth, a selectable same-address collision mode and a
//  post-reset clear sweep. Stands in for generated 45nm 1R1W macros in simulation and synthesis flows.
// PARAMETERS
//  BITS               7   data word width, >=1
//  WORD_DEPTH        64   number of words, >=2, need not be a power of two
//  ADDR_WIDTH         6   address width, must satisfy 2**ADDR_WIDTH >= WORD_DEPTH
//  READ_LATENCY       1   1 or 2; cycles from read-enable edge to rd_out update
//  WRITE_FIRST        0   0: same-addr read returns old word; 1: returns newly merged word
//  CLEAR_ON_RESET     1   1: zero every word after reset; 0: contents untouched, ready at once
//  corrupt_mem_on_X_p 1   1: X on any enable, or on the address of an enabled port, corrupts whole array
// PORTS
//  clk        in  1           rising-edge clock
//  reset      in  1           asynchronous, active-high
//  ready_out  out 1           1 = array usable; 0 while clear sweep runs
//  r_ce_in    in  1           read enable
//  r_addr_in  in  ADDR_WIDTH  read address
//  rd_out     out BITS        read data
//  rd_v_out   out 1           rd_out carries data from an accepted read
//  w_ce_in    in  1           write enable
//  w_addr_in  in  ADDR_WIDTH  write address
//  wd_in      in  BITS        write data
//  w_mask_in  in  BITS        per-bit write mask, 1 = bit written
// BEHAVIOUR
//  Reset values: ready_out = !CLEAR_ON_RESET; rd_v_out = 0; rd_out = 'x; pipeline valid bits = 0.
//  Clear FSM, states IDLE and CLEAR:
//   - Reset enters CLEAR when CLEAR_ON_RESET=1, otherwise IDLE.
//   - CLEAR writes 0 to word ctr, ctr = 0..WORD_DEPTH-1, one word per cycle.
//   - After word WORD_DEPTH-1, go to IDLE and set ready_out=1. ready_out is first high
//     WORD_DEPTH cycles after reset deasserts.
//   - Reset asserted mid-sweep restarts the sweep at ctr=0.
//  While ready_out=0, both ports are ignored: no array write, no valid read.
//  Write: on a clk edge with w_ce_in & ready_out & w_addr_in<WORD_DEPTH:
//   mem[a] <= (wd_in & w_mask_in) | (mem[a] & ~w_mask_in).
//  Read:
//   - Accepted on a clk edge with r_ce_in & ready_out.
//   - READ_LATENCY=1: rd_out updates at that edge.
//   - READ_LATENCY=2: the word is captured at that edge; rd_out updates at the next edge.
//   - rd_v_out mirrors rd_out timing, one flag per accepted read; back-to-back reads every cycle.
//  Read of an address >= WORD_DEPTH returns 'x with rd_v_out=1. Write to such an address is dropped.
//  Cycle with no accepted read: the final stage loads rd_out='x and rd_v_out=0 (read fails when
//   not enabled).
//  Collision, both ports enabled with equal addresses in one cycle:
//   - WRITE_FIRST=0: read returns the pre-write word.
//   - WRITE_FIRST=1: read returns the merged value.
//  X handling, with corrupt_mem_on_X_p=1:
//   - Trigger: ^w_ce_in or ^r_ce_in is X, or an enabled port's address is X.
//   - Effect: all words become 'x; the read captures 'x.
//   - Corruption is simulation-only (for loop), guarded with `ifndef SYNTHESIS.
//  specify block provides clk->rd_out path and setuphold/width/period placeholders for
//   every input, for SDF back-annotation.
// STRUCTURE
//  Shared package fakeram_pkg:
//   - clear-FSM state enum {IDLE, CLEAR}
//   - READ_LATENCY legality constants
//   - merge function for mask-merging a word
//  One sub-module, fakeram_rd_pipe: READ_LATENCY-stage data+valid register chain,
//   async-reset on valid bits only.
//  Elaboration-time checks: 2**ADDR_WIDTH >= WORD_DEPTH; READ_LATENCY in {1,2}.
// TESTING
//  1 Defaults. Deassert reset -> ready_out=0 for exactly 64 cycles, then 1; reading addrs
//    0..63 returns 7'h00.
//  2 Mask merge. Write 7'h7F mask 7'h7F to addr 5, then 7'h00 mask 7'h0F -> read addr 5
//    gives 7'h70, rd_v_out one cycle later (READ_LATENCY=1) or two cycles later (READ_LATENCY=2).
//  3 Collision, mem[9]=7'h11. Write 7'h22 full mask and read addr 9 in the same cycle ->
//    rd_out=7'h11 (WRITE_FIRST=0) or 7'h22 (WRITE_FIRST=1); mem[9]=7'h22 afterwards.
//  4 Reset mid-sweep. Assert reset at ctr=30 for 2 cycles -> ready_out stays 0 and rises
//    64 cycles after the second deassert; writes attempted meanwhile leave the word at 0.
//  5 Non-power-of-two. WORD_DEPTH=48, ADDR_WIDTH=6: write addr 50 -> no change to any word;
//    read addr 50 -> rd_out='x, rd_v_out=1.
//  6 X corruption. w_ce_in=1'bx for one cycle -> every subsequent read returns 'x until
//    rewritten; with corrupt_mem_on_X_p=0, contents are preserved.

Source files
------------

// File: rtl/fakeram_pkg.sv
// Shared types and helpers for the fakeram45 1R1W behavioural macro family.
package fakeram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    localparam int unsigned RD_LAT_MIN  = 1;
    localparam int unsigned RD_LAT_MAX  = 2;

    // Widest word the merge helper handles; callers cast in and out.
    localparam int unsigned MERGE_MAX_W = 1024;

    function automatic logic [MERGE_MAX_W-1:0] mask_merge(
        input logic [MERGE_MAX_W-1:0] old_w,
        input logic [MERGE_MAX_W-1:0] new_w,
        input logic [MERGE_MAX_W-1:0] mask
    );
        return (new_w & mask) | (old_w & ~mask);
    endfunction

endpackage

// File: rtl/fakeram_rd_pipe.sv
// Read-data pipeline: LAT stages of data+valid; only valid bits are reset.
module fakeram_rd_pipe #(
    parameter int unsigned W   = 7,
    parameter int unsigned LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] data_i,
    input  logic         valid_i,
    output logic [W-1:0] data_o,
    output logic         valid_o
);

    logic [W-1:0] data_q [LAT];
    logic [LAT-1:0] valid_q;

    always_ff @(posedge clk) begin
        data_q[0] <= data_i;
        for (int s = 1; s < LAT; s++) begin
            data_q[s] <= data_q[s-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= valid_i;
            for (int s = 1; s < LAT; s++) begin
                valid_q[s] <= valid_q[s-1];
            end
        end
    end

    assign data_o  = data_q[LAT-1];
    assign valid_o = valid_q[LAT-1];

endmodule

// File: rtl/fakeram45_1r1w_gen.sv
// Behavioural 1R1W SRAM with bit-masked writes, 1-2 cycle read pipeline,
// selectable same-address collision behaviour and an optional post-reset clear sweep.
module fakeram45_1r1w_gen
    import fakeram_pkg::*;
#(
    parameter int unsigned BITS               = 7,
    parameter int unsigned WORD_DEPTH         = 64,
    parameter int unsigned ADDR_WIDTH         = 6,
    parameter int unsigned READ_LATENCY       = 1,
    parameter int unsigned WRITE_FIRST        = 0,
    parameter int unsigned CLEAR_ON_RESET     = 1,
    parameter int unsigned corrupt_mem_on_X_p = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  ready_out,
    input  logic                  r_ce_in,
    input  logic [ADDR_WIDTH-1:0] r_addr_in,
    output logic [BITS-1:0]       rd_out,
    output logic                  rd_v_out,
    input  logic                  w_ce_in,
    input  logic [ADDR_WIDTH-1:0] w_addr_in,
    input  logic [BITS-1:0]       wd_in,
    input  logic [BITS-1:0]       w_mask_in
);

    if (BITS < 1 || BITS > MERGE_MAX_W) begin : g_bad_bits
        $error("fakeram45_1r1w_gen: BITS out of range");
    end
    if (WORD_DEPTH < 2) begin : g_bad_depth
        $error("fakeram45_1r1w_gen: WORD_DEPTH must be >= 2");
    end
    if ((2 ** ADDR_WIDTH) < WORD_DEPTH) begin : g_bad_aw
        $error("fakeram45_1r1w_gen: ADDR_WIDTH too small for WORD_DEPTH");
    end
    if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX) begin : g_bad_lat
        $error("fakeram45_1r1w_gen: READ_LATENCY must be 1 or 2");
    end

    logic [BITS-1:0]       mem_q [WORD_DEPTH];
    clr_state_e            state_q;
    logic [ADDR_WIDTH-1:0] ctr_q;
    logic                  ready_q;

    logic                  r_acc_c;
    logic                  r_in_rng_c;
    logic                  w_in_rng_c;
    logic                  w_hit_c;
    logic                  x_trig_c;
    logic [BITS-1:0]       w_merged_c;
    logic [BITS-1:0]       rd_word_c;

    // Port qualification, merged write word and the word a read captures this cycle.
    always_comb begin
        r_acc_c    = r_ce_in & ready_q;
        r_in_rng_c = (32'(r_addr_in) < WORD_DEPTH);
        w_in_rng_c = (32'(w_addr_in) < WORD_DEPTH);
        w_hit_c    = w_ce_in & ready_q & w_in_rng_c;
        w_merged_c = '0;
        if (w_in_rng_c) begin
            w_merged_c = BITS'(mask_merge(MERGE_MAX_W'(mem_q[w_addr_in]),
                                          MERGE_MAX_W'(wd_in),
                                          MERGE_MAX_W'(w_mask_in)));
        end
        rd_word_c = 'x;
        if (r_acc_c && r_in_rng_c) begin
            rd_word_c = mem_q[r_addr_in];
            if (WRITE_FIRST != 0 && w_hit_c && (w_addr_in == r_addr_in)) begin
                rd_word_c = w_merged_c;
            end
        end
        x_trig_c = 1'b0;
`ifndef SYNTHESIS
        x_trig_c = (corrupt_mem_on_X_p != 0) &&
                   ($isunknown(w_ce_in) || $isunknown(r_ce_in) ||
                    ((w_ce_in === 1'b1) && $isunknown(w_addr_in)) ||
                    ((r_ce_in === 1'b1) && $isunknown(r_addr_in)));
        if (x_trig_c) begin
            rd_word_c = 'x;
        end
`endif
    end

    // Clear sweep: one word per cycle after reset, then the array opens up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            ctr_q   <= '0;
            ready_q <= (CLEAR_ON_RESET == 0);
        end else begin
            case (state_q)
                CLEAR: begin
                    if (ctr_q == ADDR_WIDTH'(WORD_DEPTH - 1)) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        ctr_q   <= '0;
                    end else begin
                        ctr_q <= ctr_q + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Array storage; an unknown control/address wipes the whole array in simulation.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[ctr_q] <= '0;
        end else if (w_hit_c) begin
            mem_q[w_addr_in] <= w_merged_c;
        end
`ifndef SYNTHESIS
        if (x_trig_c) begin
            for (int i = 0; i < WORD_DEPTH; i++) begin
                mem_q[i] <= 'x;
            end
        end
`endif
    end

    fakeram_rd_pipe #(
        .W   (BITS),
        .LAT (READ_LATENCY)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (reset),
        .data_i  (rd_word_c),
        .valid_i (r_acc_c),
        .data_o  (rd_out),
        .valid_o (rd_v_out)
    );

    assign ready_out = ready_q;

    // Zero-valued timing hooks for SDF back-annotation.
    specify
        specparam t_ck_q = 0.0, t_setup = 0.0, t_hold = 0.0, t_pw = 0.0, t_per = 0.0;
        (posedge clk *> rd_out) = (t_ck_q, t_ck_q);
        $setuphold(posedge clk, r_ce_in,   t_setup, t_hold);
        $setuphold(posedge clk, r_addr_in, t_setup, t_hold);
        $setuphold(posedge clk, w_ce_in,   t_setup, t_hold);
        $setuphold(posedge clk, w_addr_in, t_setup, t_hold);
        $setuphold(posedge clk, wd_in,     t_setup, t_hold);
        $setuphold(posedge clk, w_mask_in, t_setup, t_hold);
        $width(posedge reset, t_pw);
        $width(posedge clk, t_pw);
        $width(negedge clk, t_pw);
        $period(posedge clk, t_per);
    endspecify

endmodule

// File: tb/tb_fakeram45_1r1w_gen.sv
// Directed bench: instance A uses defaults, instance B is 48 deep, 2-cycle read, write-first.
module tb_fakeram45_1r1w_gen;

    logic       clk;
    logic       reset;
    logic       r_ce;
    logic [5:0] r_addr;
    logic       w_ce;
    logic [5:0] w_addr;
    logic [6:0] wd;
    logic [6:0] wmask;

    logic       ready_a, rdv_a, ready_b, rdv_b;
    logic [6:0] rd_a, rd_b;

    int  total  = 0;
    int  passed = 0;
    int  fails  = 0;
    bit  four_state;

    fakeram45_1r1w_gen dut_a (
        .clk       (clk),
        .reset     (reset),
        .ready_out (ready_a),
        .r_ce_in   (r_ce),
        .r_addr_in (r_addr),
        .rd_out    (rd_a),
        .rd_v_out  (rdv_a),
        .w_ce_in   (w_ce),
        .w_addr_in (w_addr),
        .wd_in     (wd),
        .w_mask_in (wmask)
    );

    fakeram45_1r1w_gen #(
        .BITS               (7),
        .WORD_DEPTH         (48),
        .ADDR_WIDTH         (6),
        .READ_LATENCY       (2),
        .WRITE_FIRST        (1),
        .CLEAR_ON_RESET     (1),
        .corrupt_mem_on_X_p (0)
    ) dut_b (
        .clk       (clk),
        .reset     (reset),
        .ready_out (ready_b),
        .r_ce_in   (r_ce),
        .r_addr_in (r_addr),
        .rd_out    (rd_b),
        .rd_v_out  (rdv_b),
        .w_ce_in   (w_ce),
        .w_addr_in (w_addr),
        .wd_in     (wd),
        .w_mask_in (wmask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] expw(input int a);
        if (a == 5) return 7'h70;
        if (a == 9) return 7'h22;
        return 7'h00;
    endfunction

    initial begin
        logic probe;
        probe      = 1'bx;
        four_state = $isunknown(probe);

        reset = 1'b1; r_ce = 1'b0; r_addr = '0; w_ce = 1'b0;
        w_addr = '0; wd = '0; wmask = '0;
        repeat (3) step();

        chk1("rst_ready_a", ready_a, 1'b0);
        chk1("rst_rdv_a",   rdv_a,   1'b0);
        chk1("rst_ready_b", ready_b, 1'b0);
        chk1("rst_rdv_b",   rdv_b,   1'b0);
        if (four_state) chk7("rst_rd_a_x", rd_a, 7'bx);

        // Clear sweep length after reset release
        reset = 1'b0;
        chk1("sweep_ready_a_0", ready_a, 1'b0);
        for (int n = 1; n <= 64; n++) begin
            step();
            chk1($sformatf("sweep_ready_a_%0d", n), ready_a, (n >= 64));
            chk1($sformatf("sweep_ready_b_%0d", n), ready_b, (n >= 48));
        end

        // Every word reads back zero; back-to-back reads
        for (int i = 0; i <= 64; i++) begin
            r_ce   = (i < 64);
            r_addr = 6'(i);
            step();
            if (i < 64) begin
                chk7($sformatf("clr_rd_a_%0d", i), rd_a, 7'h00);
                chk1($sformatf("clr_rdv_a_%0d", i), rdv_a, 1'b1);
            end
            if (i >= 1) begin
                chk1($sformatf("clr_rdv_b_%0d", i - 1), rdv_b, 1'b1);
                if (i - 1 < 48) chk7($sformatf("clr_rd_b_%0d", i - 1), rd_b, 7'h00);
            end
        end
        r_ce = 1'b0;
        step();
        chk1("idle_rdv_a", rdv_a, 1'b0);
        chk1("idle_rdv_b", rdv_b, 1'b0);

        // Mask merge on word 5
        w_ce = 1'b1; w_addr = 6'd5; wd = 7'h7F; wmask = 7'h7F;
        step();
        wd = 7'h00; wmask = 7'h0F;
        step();
        w_ce = 1'b0; r_ce = 1'b1; r_addr = 6'd5;
        step();
        chk7("merge_rd_a",  rd_a,  7'h70);
        chk1("merge_rdv_a", rdv_a, 1'b1);
        chk1("merge_rdv_b_early", rdv_b, 1'b0);
        r_ce = 1'b0;
        step();
        chk7("merge_rd_b",  rd_b,  7'h70);
        chk1("merge_rdv_b", rdv_b, 1'b1);
        chk1("merge_rdv_a_off", rdv_a, 1'b0);

        // Same-address collision on word 9
        w_ce = 1'b1; w_addr = 6'd9; wd = 7'h11; wmask = 7'h7F;
        step();
        wd = 7'h22; r_ce = 1'b1; r_addr = 6'd9;
        step();
        chk7("coll_rd_a_old", rd_a, 7'h11);
        w_ce = 1'b0; r_ce = 1'b0;
        step();
        chk7("coll_rd_b_new", rd_b, 7'h22);
        r_ce = 1'b1;
        step();
        chk7("coll_after_a", rd_a, 7'h22);
        r_ce = 1'b0;
        step();
        chk7("coll_after_b", rd_b, 7'h22);

        // Address 50: in range for A, beyond depth for B
        w_ce = 1'b1; w_addr = 6'd50; wd = 7'h55; wmask = 7'h7F;
        step();
        w_ce = 1'b0; r_ce = 1'b1; r_addr = 6'd50;
        step();
        chk7("oor_rd_a",  rd_a,  7'h55);
        chk1("oor_rdv_a", rdv_a, 1'b1);
        r_ce = 1'b0;
        step();
        chk1("oor_rdv_b", rdv_b, 1'b1);
        if (four_state) chk7("oor_rd_b_x", rd_b, 7'bx);
        for (int i = 0; i <= 48; i++) begin
            r_ce   = (i < 48);
            r_addr = 6'(i);
            step();
            if (i < 48) chk7($sformatf("scan_rd_a_%0d", i), rd_a, expw(i));
            if (i >= 1) chk7($sformatf("scan_rd_b_%0d", i - 1), rd_b, expw(i - 1));
        end
        r_ce = 1'b0;

        // Reset at ctr=30, held two cycles; accesses during the sweep are ignored
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (30) step();
        chk1("mid_ready_a_30", ready_a, 1'b0);
        reset = 1'b1;
        step();
        step();
        chk1("mid_rst_ready_a", ready_a, 1'b0);
        chk1("mid_rst_ready_b", ready_b, 1'b0);
        reset = 1'b0;
        w_ce = 1'b1; w_addr = 6'd3; wd = 7'h7F; wmask = 7'h7F;
        r_ce = 1'b1; r_addr = 6'd3;
        for (int n = 1; n <= 64; n++) begin
            if (n == 47) begin
                w_ce = 1'b0;
                r_ce = 1'b0;
            end
            step();
            chk1($sformatf("mid_ready_a_%0d", n), ready_a, (n >= 64));
            chk1($sformatf("mid_ready_b_%0d", n), ready_b, (n >= 48));
            chk1($sformatf("mid_rdv_a_%0d", n), rdv_a, 1'b0);
            chk1($sformatf("mid_rdv_b_%0d", n), rdv_b, 1'b0);
        end
        r_ce = 1'b1; r_addr = 6'd3;
        step();
        chk7("mid_word3_a", rd_a, 7'h00);
        r_addr = 6'd5;
        step();
        chk7("mid_word3_b", rd_b, 7'h00);
        chk7("mid_word5_a", rd_a, 7'h00);
        r_ce = 1'b0;
        step();
        chk7("mid_word5_b", rd_b, 7'h00);

        // Unknown write enable corrupts A only
        if (four_state) begin
            w_ce = 1'b1; w_addr = 6'd5; wd = 7'h70; wmask = 7'h7F;
            step();
            w_ce = 1'bx; w_addr = 6'd12;
            step();
            w_ce = 1'b0; r_ce = 1'b1; r_addr = 6'd5;
            step();
            chk7("x_rd_a_5", rd_a, 7'bx);
            r_addr = 6'd20;
            step();
            chk7("x_rd_b_5", rd_b, 7'h70);
            chk7("x_rd_a_20", rd_a, 7'bx);
            r_ce = 1'b0;
            w_ce = 1'b1; w_addr = 6'd5; wd = 7'h2A; wmask = 7'h7F;
            step();
            w_ce = 1'b0; r_ce = 1'b1; r_addr = 6'd5;
            step();
            chk7("x_rewrite_a", rd_a, 7'h2A);
            r_ce = 1'b0;
            step();
            chk7("x_rewrite_b", rd_b, 7'h2A);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
